// File: rtl/i2c_reg_ctrl.sv
// I2C slave sequencer: START/STOP decode, 7-bit address match, sub-address pointer
// and auto-incrementing byte writes/reads onto the internal config/status register file.
module i2c_reg_ctrl #(
   parameter logic [6:0]  DEV_ADDR = 7'h70,
   parameter int unsigned PTR_W    = 7,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sda_in,
   input  logic             scl_in,
   output logic             sda_oe,
   output logic [PTR_W-1:0] reg_addr,
   output logic [7:0]       reg_wdata,
   output logic             reg_we,
   output logic             reg_re,
   input  logic [7:0]       reg_rdata,
   output logic             busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [3:0] {
      IDLE, DEVADDR, ACK_DEV, SUBADDR, ACK_SUB, WDATA, ACK_WR, RDATA, MACK, IGNORE
   } state_t;

   logic [SYNC_STG-1:0] scl_sync_q, sda_sync_q;
   logic                scl_h_q, sda_h_q;
   logic                scl_s, sda_s;
   logic                scl_rise, scl_fall, start_det, stop_det;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                we_q, we_d, re_q, re_d;
   logic                oe_q, oe_d, busy_q, busy_d;
   logic                rw_q, rw_d;
   logic                ld_q, ld_d;
   logic                pend_q, pend_d;
   logic [7:0]          byte_in;

   // Pad synchronizers plus one history flop; reset to the idle-high bus level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STG-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STG-2:0], sda_in};
         scl_h_q    <= scl_sync_q[SYNC_STG-1];
         sda_h_q    <= sda_sync_q[SYNC_STG-1];
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STG-1];
   assign sda_s     = sda_sync_q[SYNC_STG-1];
   assign scl_rise  = scl_s & ~scl_h_q;
   assign scl_fall  = ~scl_s & scl_h_q;
   assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
   assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
   assign byte_in   = {shift_q[6:0], sda_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         ptr_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         rw_q    <= 1'b0;
         ld_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         rw_q    <= rw_d;
         ld_q    <= ld_d;
         pend_q  <= pend_d;
      end
   end

   // In ACK states oe_q tells the two SCL falls apart: first drives the ACK, second ends it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      oe_d    = oe_q;
      busy_d  = busy_q;
      rw_d    = rw_q;
      ld_d    = re_q;
      pend_d  = pend_q;
      if (start_det) begin
         state_d = DEVADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
         ld_d    = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         ld_d    = 1'b0;
      end else begin
         case (state_q)
            DEVADDR: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d = '0;
                  if (byte_in[7:1] == DEV_ADDR) begin
                     state_d = ACK_DEV;
                     busy_d  = 1'b1;
                     rw_d    = byte_in[0];
                  end else begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            ACK_DEV: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else if (rw_q) begin
                  // Hold the ACK level until the fetched byte's MSB replaces it
                  state_d = RDATA;
                  re_d    = 1'b1;
                  pend_d  = 1'b0;
               end else begin
                  oe_d    = 1'b0;
                  state_d = SUBADDR;
               end
            end
            SUBADDR: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d   = '0;
                  ptr_d   = PTR_W'(byte_in);
                  state_d = ACK_SUB;
               end
            end
            ACK_SUB: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else begin
                  oe_d    = 1'b0;
                  state_d = WDATA;
               end
            end
            WDATA: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d   = '0;
                  we_d    = 1'b1;
                  wdata_d = byte_in;
                  state_d = ACK_WR;
               end
            end
            ACK_WR: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else begin
                  oe_d    = 1'b0;
                  ptr_d   = ptr_q + PTR_W'(1);
                  state_d = WDATA;
               end
            end
            RDATA: begin
               if (ld_q) begin
                  shift_d = reg_rdata;
                  cnt_d   = '0;
                  if (!pend_q) oe_d = ~reg_rdata[7];
               end else if (scl_rise) begin
                  cnt_d = CNT_W'(cnt_q + CNT_W'(1));
               end else if (scl_fall) begin
                  if (pend_q) begin
                     oe_d   = ~shift_q[7];
                     pend_d = 1'b0;
                  end else if (cnt_q == CNT_W'(8)) begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = MACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end
            MACK: if (scl_rise) begin
               cnt_d = '0;
               if (!sda_s) begin
                  ptr_d   = ptr_q + PTR_W'(1);
                  re_d    = 1'b1;
                  pend_d  = 1'b1;
                  state_d = RDATA;
               end else begin
                  busy_d  = 1'b0;
                  state_d = IGNORE;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = oe_q;
   assign reg_addr  = ptr_q;
   assign reg_wdata = wdata_q;
   assign reg_we    = we_q;
   assign reg_re    = re_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: bit-level I2C master, register-file model and a strobe
// scoreboard; read bytes on SDA are checked against the bench's own expected memory.
module tb_i2c_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_oe, reg_we, reg_re, busy;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;
   logic       sda_line;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic       is_wr;
      logic [6:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] mem [128];
   logic [7:0] exp_mem [128];
   logic       watch, oe_seen, busy_seen, strobe_seen;

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;

   i2c_reg_ctrl #(.DEV_ADDR(7'h70), .PTR_W(7), .SYNC_STG(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sda_in    (sda_line),
      .scl_in    (scl_m),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Register file model: registered read data, one clk after reg_re
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'(i * 7 + 3);
         reg_rdata <= 8'h00;
      end else begin
         if (reg_we) mem[reg_addr] <= reg_wdata;
         if (reg_re) reg_rdata <= mem[reg_addr];
      end
   end

   always @(negedge clk) begin
      if (!rst && (reg_we || reg_re)) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_strobe", 32'({reg_we, reg_re}), 32'd0);
         end else begin
            ev_t ev;
            ev = exp_q.pop_front();
            check("sb_kind_we", 32'(reg_we), 32'(ev.is_wr));
            check("sb_addr", 32'(reg_addr), 32'(ev.addr));
            if (ev.is_wr) check("sb_wdata", 32'(reg_wdata), 32'(ev.data));
         end
      end
      if (watch) begin
         if (sda_oe) oe_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
         if (reg_we || reg_re) strobe_seen = 1'b1;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
      exp_q.push_back('{is_wr: 1'b1, addr: a, data: d});
      exp_mem[a] = d;
   endtask

   task automatic push_rd(input logic [6:0] a);
      exp_q.push_back('{is_wr: 1'b0, addr: a, data: 8'h00});
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; wait_clk(6);
      scl_m = 1'b1; wait_clk(6);
      sda_m = 1'b0; wait_clk(6);
      scl_m = 1'b0; wait_clk(2);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wait_clk(6);
      scl_m = 1'b1; wait_clk(6);
      sda_m = 1'b1; wait_clk(6);
   endtask

   task automatic clk_bit(input logic b, output logic s);
      sda_m = b;    wait_clk(6);
      scl_m = 1'b1; wait_clk(4);
      s = sda_line; wait_clk(4);
      scl_m = 1'b0; wait_clk(2);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic nak, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(nak, s);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] d;
      for (int i = 0; i < 128; i++) exp_mem[i] = 8'(i * 7 + 3);
      watch = 1'b0; oe_seen = 1'b0; busy_seen = 1'b0; strobe_seen = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1;
      wait_clk(3);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_we_re", 32'({reg_we, reg_re}), 32'd0);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_wdata", 32'(reg_wdata), 32'd0);
      rst = 1'b0;
      wait_clk(5);

      // Write E0,0A,55,1F
      i2c_start();
      send_byte(8'hE0, ack); check("w1_ack_dev", 32'(ack), 32'd0);
      check("w1_busy", 32'(busy), 32'd1);
      send_byte(8'h0A, ack); check("w1_ack_sub", 32'(ack), 32'd0);
      push_wr(7'd10, 8'h55);
      send_byte(8'h55, ack); check("w1_ack_d0", 32'(ack), 32'd0);
      push_wr(7'd11, 8'h1F);
      send_byte(8'h1F, ack); check("w1_ack_d1", 32'(ack), 32'd0);
      i2c_stop();
      check("w1_busy_after_stop", 32'(busy), 32'd0);

      // Pointer wrap 127 -> 0
      i2c_start();
      send_byte(8'hE0, ack); check("w2_ack_dev", 32'(ack), 32'd0);
      send_byte(8'h7F, ack); check("w2_ack_sub", 32'(ack), 32'd0);
      push_wr(7'd127, 8'hFA);
      send_byte(8'hFA, ack); check("w2_ack_d0", 32'(ack), 32'd0);
      push_wr(7'd0, 8'h4D);
      send_byte(8'h4D, ack); check("w2_ack_d1", 32'(ack), 32'd0);
      i2c_stop();

      // Read 126, 127 with repeated START, master ACK then NAK
      i2c_start();
      send_byte(8'hE0, ack); check("r_ack_dev_w", 32'(ack), 32'd0);
      send_byte(8'h7E, ack); check("r_ack_sub", 32'(ack), 32'd0);
      i2c_start();
      push_rd(7'd126);
      send_byte(8'hE1, ack); check("r_ack_dev_r", 32'(ack), 32'd0);
      push_rd(7'd127);
      read_byte(1'b0, d); check("r_data126", 32'(d), 32'(exp_mem[126]));
      read_byte(1'b1, d); check("r_data127", 32'(d), 32'(exp_mem[127]));
      oe_seen = 1'b0; watch = 1'b1;
      i2c_stop();
      watch = 1'b0;
      check("r_oe_after_nak", 32'(oe_seen), 32'd0);
      check("r_busy_after", 32'(busy), 32'd0);

      // Address mismatch: bus must stay untouched
      oe_seen = 1'b0; busy_seen = 1'b0; strobe_seen = 1'b0; watch = 1'b1;
      i2c_start();
      send_byte(8'hE2, ack); check("mm_nak_addr", 32'(ack), 32'd1);
      send_byte(8'h0A, ack); check("mm_nak_b1", 32'(ack), 32'd1);
      send_byte(8'h55, ack); check("mm_nak_b2", 32'(ack), 32'd1);
      i2c_stop();
      watch = 1'b0;
      check("mm_oe_seen", 32'(oe_seen), 32'd0);
      check("mm_busy_seen", 32'(busy_seen), 32'd0);
      check("mm_strobe_seen", 32'(strobe_seen), 32'd0);

      // STOP after 5 data bits: no write, pointer stays at 0x20
      i2c_start();
      send_byte(8'hE0, ack); check("p5_ack_dev", 32'(ack), 32'd0);
      send_byte(8'h20, ack); check("p5_ack_sub", 32'(ack), 32'd0);
      clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
      i2c_stop();
      i2c_start();
      push_rd(7'h20);
      send_byte(8'hE1, ack); check("p5_ack_dev_r", 32'(ack), 32'd0);
      read_byte(1'b1, d); check("p5_data20", 32'(d), 32'(exp_mem[32]));
      i2c_stop();

      // Reset pulse in the middle of data bit 5
      i2c_start();
      send_byte(8'hE0, ack); check("rs_ack_dev", 32'(ack), 32'd0);
      send_byte(8'h0A, ack); check("rs_ack_sub", 32'(ack), 32'd0);
      clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
      sda_m = 1'b1; wait_clk(3);
      scl_m = 1'b1; wait_clk(2);
      check("rs_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("rs_oe_async", 32'(sda_oe), 32'd0);
      check("rs_busy_async", 32'(busy), 32'd0);
      wait_clk(3);
      rst = 1'b0;
      for (int i = 0; i < 128; i++) exp_mem[i] = 8'(i * 7 + 3);
      wait_clk(4);
      i2c_start();
      send_byte(8'hE0, ack); check("rs2_ack_dev", 32'(ack), 32'd0);
      send_byte(8'h0A, ack); check("rs2_ack_sub", 32'(ack), 32'd0);
      push_wr(7'd10, 8'h55);
      send_byte(8'h55, ack); check("rs2_ack_d0", 32'(ack), 32'd0);
      i2c_stop();

      wait_clk(20);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
